// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR and its output requantiser.
//   DEF_*      : default widths / shift shared by FIR, requantiser and bench
//   SAT_MAX/MIN: clip bounds of the default 16-bit output
//   requant()  : reference round-half-up / shift / clip of one sample
package fir_pkg;

  localparam int DEF_IN_WIDTH  = 37;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_SHIFT     = 15;

  localparam longint SAT_MAX = (longint'(1) <<< (DEF_OUT_WIDTH - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (DEF_OUT_WIDTH - 1));

  typedef struct packed {
    logic                            sat;
    logic signed [DEF_OUT_WIDTH-1:0] data;
  } rq_t;

  // 64-bit working width leaves ample headroom for a 37-bit input plus
  // the rounding constant, so no wrap can occur before the shift.
  function automatic rq_t requant(input logic signed [63:0] y, input int shift);
    longint r;
    rq_t    o;
    r     = (y + (longint'(1) <<< (shift - 1))) >>> shift;
    o.sat = (r > SAT_MAX) || (r < SAT_MIN);
    if (r > SAT_MAX)      o.data = DEF_OUT_WIDTH'(SAT_MAX);
    else if (r < SAT_MIN) o.data = DEF_OUT_WIDTH'(SAT_MIN);
    else                  o.data = DEF_OUT_WIDTH'(r);
    return o;
  endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// Sample stream bundle for the requantiser.
//   y_in/y_valid     : wide FIR accumulator stream (no back-pressure)
//   m_data/m_valid/m_ready : requantised valid/ready output
// master = stream producer/consumer side (FIR + DAC path), slave = requantiser.
interface fir_out_requant_if
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
);

  logic signed [IN_WIDTH-1:0]  y_in;
  logic                        y_valid;
  logic signed [OUT_WIDTH-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;

  modport master (output y_in, y_valid, m_ready, input  m_data, m_valid);
  modport slave  (input  y_in, y_valid, m_ready, output m_data, m_valid);

endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head.
//   clk/rst     : clock, async active-high reset
//   wr_en_i/wr_data_i : write request; dropped when full and not reading
//   rd_en_i     : consumer ready; a read happens when rd_valid_o && rd_en_i
//   rd_data_o/rd_valid_o : registered head of queue
//   level_o     : occupancy
//   drop_o      : write request discarded this cycle
module fir_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [AW:0]      level_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [WIDTH-1:0] data_q, data_d, head_d;
  logic             valid_q, valid_d;
  logic             full, rd_fire, wr_fire;

  // Extra wrap bit: equal low bits with differing MSB means full.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en_i && valid_q;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_fire = wr_en_i && (!full || rd_fire);
  assign drop_o  = wr_en_i && full && !rd_fire;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_fire);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
    level_d  = level_q;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    // Next head comes from the incoming word when it lands in the head slot
    // (FIFO empty after this cycle's read), otherwise from storage.
    if (wr_fire && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = wr_data_i;
    else                                                    head_d = mem[rd_ptr_d[AW-1:0]];
    valid_d = (wr_ptr_d != rd_ptr_d);
    data_d  = valid_d ? head_d : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign level_o    = level_q;

endmodule

// File: rtl/fir_out_requant.sv
// Requantises the wide FIR accumulator stream to OUT_WIDTH bits
// (round-half-up, arithmetic shift, saturate), buffers results in a FIFO
// and keeps sticky saturation / overflow statistics.
//   clk/rst    : clock, async active-high reset
//   bus        : y_in/y_valid in, m_data/m_valid/m_ready out
//   clr_stats  : synchronous clear of flags and counters
//   level      : FIFO occupancy
//   sat_flag/sat_count  : clipped samples (count saturates at all-ones)
//   ovf_flag/drop_count : samples dropped on a full FIFO
module fir_out_requant
  import fir_pkg::*;
#(
  parameter  int IN_WIDTH   = DEF_IN_WIDTH,
  parameter  int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter  int SHIFT      = DEF_SHIFT,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_WIDTH  = 8,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
)(
  input  logic                 clk,
  input  logic                 rst,
  fir_out_requant_if.slave     bus,
  input  logic                 clr_stats,
  output logic [LW-1:0]        level,
  output logic                 sat_flag,
  output logic [CNT_WIDTH-1:0] sat_count,
  output logic                 ovf_flag,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic signed [IN_WIDTH:0] RND  = (IN_WIDTH+1)'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;  // -MAXV-1

  logic [2:1]                  vld_pipe_q;
  logic signed [IN_WIDTH:0]    ext, rsum, s1_d, s1_q;
  logic signed [OUT_WIDTH-1:0] s2_d, s2_q;
  logic                        sat_d, sat_q;
  logic                        drop, sat_ev;
  logic [CNT_WIDTH-1:0]        sat_cnt_d, sat_cnt_q, drop_cnt_d, drop_cnt_q;
  logic                        sat_flag_d, sat_flag_q, ovf_flag_d, ovf_flag_q;

  // Stage 1: one guard bit so adding the rounding constant cannot wrap.
  always_comb begin
    ext  = {bus.y_in[IN_WIDTH-1], bus.y_in};
    rsum = ext + RND;
    s1_d = rsum >>> SHIFT;
  end

  // Stage 2: clip, with the clip event travelling alongside the data.
  always_comb begin
    sat_d = 1'b0;
    s2_d  = s1_q[OUT_WIDTH-1:0];
    if (s1_q > MAXV) begin
      s2_d  = OUT_WIDTH'(MAXV);
      sat_d = 1'b1;
    end else if (s1_q < MINV) begin
      s2_d  = OUT_WIDTH'(MINV);
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      sat_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], bus.y_valid};
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      sat_q      <= sat_d;
    end
  end

  fir_sync_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (vld_pipe_q[2]),
    .wr_data_i  (s2_q),
    .rd_en_i    (bus.m_ready),
    .rd_data_o  (bus.m_data),
    .rd_valid_o (bus.m_valid),
    .level_o    (level),
    .drop_o     (drop)
  );

  // Clipping counts every valid stage-2 sample, even one the FIFO drops.
  assign sat_ev = vld_pipe_q[2] && sat_q;

  // Clear first, then count a coincident event on top of the cleared value.
  always_comb begin
    sat_cnt_d  = clr_stats ? '0 : sat_cnt_q;
    drop_cnt_d = clr_stats ? '0 : drop_cnt_q;
    if (sat_ev && !(&sat_cnt_d))  sat_cnt_d  = sat_cnt_d + CNT_WIDTH'(1);
    if (drop   && !(&drop_cnt_d)) drop_cnt_d = drop_cnt_d + CNT_WIDTH'(1);
    sat_flag_d = (sat_flag_q && !clr_stats) || sat_ev;
    ovf_flag_d = (ovf_flag_q && !clr_stats) || drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      sat_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      sat_flag_q <= sat_flag_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign sat_count  = sat_cnt_q;
  assign drop_count = drop_cnt_q;
  assign sat_flag   = sat_flag_q;
  assign ovf_flag   = ovf_flag_q;

endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;
  import fir_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_stats;
  logic [3:0] level;
  logic       sat_flag, ovf_flag;
  logic [7:0] sat_count, drop_count;

  int vectors = 0;
  int misses  = 0;

  fir_out_requant_if bus ();

  fir_out_requant dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .level      (level),
    .sat_flag   (sat_flag),
    .sat_count  (sat_count),
    .ovf_flag   (ovf_flag),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks in the main
  // block run right after this returns, i.e. #1 after the edge.
  task automatic tick(input logic v, input longint y, input logic rdy);
    @(posedge clk);
    #1;
    bus.y_valid = v;
    bus.y_in    = y[DEF_IN_WIDTH-1:0];
    bus.m_ready = rdy;
    clr_stats   = 1'b0;
  endtask

  // Scoreboard: 2-stage model pipeline feeding a queue of expected outputs.
  // Evaluated at the falling edge, predicting what the next rising edge does.
  logic signed [15:0] q[$];
  int   msat, mdrop;
  logic msatf, movf, p1v, p2v, rd;
  rq_t  p1, p2;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      msat = 0; mdrop = 0; msatf = 1'b0; movf = 1'b0;
      p1v = 1'b0; p2v = 1'b0; p1 = '0; p2 = '0;
    end else begin
      chk("sb_m_valid",    bus.m_valid, longint'(q.size() != 0));
      chk("sb_level",      level,       q.size());
      chk("sb_sat_count",  sat_count,   msat);
      chk("sb_drop_count", drop_count,  mdrop);
      chk("sb_sat_flag",   sat_flag,    msatf);
      chk("sb_ovf_flag",   ovf_flag,    movf);
      rd = (q.size() != 0) && bus.m_ready;
      if (rd) chk("sb_m_data", bus.m_data, q.pop_front());
      if (clr_stats) begin
        msat = 0; mdrop = 0; msatf = 1'b0; movf = 1'b0;
      end
      if (p2v) begin
        if (p2.sat) begin
          msatf = 1'b1;
          if (msat < 255) msat++;
        end
        if (q.size() == 8 && !rd) begin
          movf = 1'b1;
          if (mdrop < 255) mdrop++;
        end else begin
          q.push_back(p2.data);
        end
      end
      p2v = p1v;
      p2  = p1;
      p1v = bus.y_valid;
      p1  = requant(bus.y_in, DEF_SHIFT);
    end
  end

  initial begin
    longint in1[5] = '{32768000, 16384, -16384, -16385, 49151};
    longint ex1[5] = '{1000, 1, 0, -1, 1};
    longint maxin  = (longint'(1) <<< 36) - 1;
    longint minin  = -(longint'(1) <<< 36);
    real    ph, w, amp;

    rst = 1'b0; clr_stats = 1'b0;
    bus.y_valid = 1'b0; bus.y_in = '0; bus.m_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data",  bus.m_data,  0);
    chk("rst_level",   level,       0);
    chk("rst_sat",     sat_count,   0);
    chk("rst_drop",    drop_count,  0);
    chk("rst_flags",   {sat_flag, ovf_flag}, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    rst = 1'b0;
    tick(0, 0, 1);

    // 1: rounding and 3-cycle latency
    for (int i = 0; i < 8; i++) begin
      tick(i < 5, (i < 5) ? in1[i] : 0, 1);
      if (i == 2) chk("t1_latency", bus.m_valid, 0);
      if (i >= 3) begin
        chk("t1_valid", bus.m_valid, 1);
        chk("t1_data",  bus.m_data,  ex1[i-3]);
      end
    end
    chk("t1_sat_count", sat_count, 0);

    // 2: saturation both ways, then clear
    for (int i = 0; i < 6; i++) begin
      tick(i < 2, (i == 0) ? maxin : minin, 1);
      if (i == 3) chk("t2_pos_clip", bus.m_data, 32767);
      if (i == 4) chk("t2_neg_clip", bus.m_data, -32768);
    end
    chk("t2_sat_flag",  sat_flag,  1);
    chk("t2_sat_count", sat_count, 2);
    clr_stats = 1'b1;
    tick(0, 0, 1);
    chk("t2_clr_flag",  sat_flag,  0);
    chk("t2_clr_count", sat_count, 0);

    // 3: back-pressure, overflow, ordered drain with stable head
    for (int i = 0; i < 13; i++) begin
      tick(i < 10, longint'(i + 1) * 32768, 0);
      if (i >= 3) chk("t3_stall_data", bus.m_data, 1);
    end
    chk("t3_level", level,      8);
    chk("t3_drop",  drop_count, 2);
    chk("t3_ovf",   ovf_flag,   1);
    for (int j = 0; j < 8; j++) begin
      tick(0, 0, 1);
      chk("t3_drain_valid", bus.m_valid, 1);
      chk("t3_drain_data",  bus.m_data,  j + 1);
    end
    tick(0, 0, 1);
    chk("t3_empty", bus.m_valid, 0);

    // 4: full FIFO, read and write on the same edge
    for (int i = 0; i < 12; i++) begin
      tick(i < 9, longint'(11 + i) * 32768, i == 10);
      if (i == 10) chk("t4_full_level", level, 8);
      if (i == 11) begin
        chk("t4_rw_level", level,       8);
        chk("t4_rw_drop",  drop_count,  2);
        chk("t4_rw_head",  bus.m_data,  12);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tick(0, 0, 1);
      chk("t4_drain_data", bus.m_data, 12 + j);
    end
    tick(0, 0, 1);
    chk("t4_empty", bus.m_valid, 0);

    // 5: asynchronous reset with data buffered
    for (int i = 0; i < 8; i++) tick(i < 5, longint'(21 + i) * 32768, 0);
    chk("t5_level_pre", level, 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_m_valid", bus.m_valid, 0);
    chk("t5_level",   level,       0);
    chk("t5_drop",    drop_count,  0);
    chk("t5_flags",   {sat_flag, ovf_flag}, 0);
    chk("t5_sat",     sat_count,   0);
    tick(0, 0, 0);
    rst = 1'b0;
    tick(1, longint'(26) * 32768, 1);
    for (int j = 0; j < 3; j++) begin
      tick(0, 0, 1);
      if (j < 2) chk("t5_latency", bus.m_valid, 0);
      else begin
        chk("t5_new_valid", bus.m_valid, 1);
        chk("t5_new_data",  bus.m_data,  26);
        chk("t5_new_level", level,       1);
      end
    end

    // 6: sine sweep with random back-pressure
    tick(0, 0, 1);
    clr_stats = 1'b1;
    tick(0, 0, 1);
    ph = 0.0; w = 0.05; amp = 1.1 * (2.0 ** 30);
    for (int i = 0; i < 256; i++) begin
      tick(1, longint'(amp * $sin(ph)), 1'($urandom_range(0, 1)));
      ph = ph + w;
      w  = w + 0.002;
    end
    for (int i = 0; i < 40; i++) tick(0, 0, 1);
    chk("t6_sb_empty", q.size(),    0);
    chk("t6_m_valid",  bus.m_valid, 0);
    chk("t6_drop",     drop_count,  mdrop);
    chk("t6_sat_flag", sat_flag,    1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
Consumer-side companion to the serial FIR. It accepts the wide accumulator stream (y_in/y_valid) and requantises each sample to 16 bits with round-half-up, a right shift and saturation. Results are buffered in a small FIFO and presented on a valid/ready output toward the DAC/log path. Sticky saturation and overflow statistics let software detect gain or back-pressure problems.

Parameters:
IN_WIDTH, 37, width of signed FIR accumulator input
OUT_WIDTH, 16, width of signed requantised output
SHIFT, 15, arithmetic right shift applied after rounding (1..IN_WIDTH-2)
FIFO_DEPTH, 8, output buffer entries (power of 2, >=2)
CNT_WIDTH, 8, width of the statistics counters

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
y_in  in  IN_WIDTH  signed FIR output sample
y_valid  in  1  y_in valid this cycle; no back-pressure toward the FIR
m_data  out  OUT_WIDTH  signed requantised sample (FIFO head)
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data when m_valid && m_ready
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
clr_stats  in  1  synchronous clear of the flags and counters
sat_flag  out  1  sticky: at least one sample clipped
sat_count  out  CNT_WIDTH  clipped-sample count, saturating at all-ones
ovf_flag  out  1  sticky: at least one sample dropped because the FIFO was full
drop_count  out  CNT_WIDTH  dropped-sample count, saturating at all-ones

Behaviour:
- Reset (async assert, sync release): every output is 0, the FIFO is empty, all pipeline valid bits are cleared. Reset mid-stream discards in-flight and buffered samples.
- Stage 1 (registered at the edge that samples y_valid): r = (y_in sign-extended to IN_WIDTH+1) + 2^(SHIFT-1), then arithmetic shift right by SHIFT. The extra bit prevents wrap when the rounding constant is added.
- Stage 2 (registered): clip r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The clip event is flagged alongside the data.
- Stage 3: FIFO write at the next edge.
- Latency: with y_valid high before edge k and the FIFO empty, m_valid is high after edge k+2, i.e. 3 cycles.
- Throughput: one sample per cycle sustained when m_ready=1.
- FIFO is first-word-fall-through. m_data and m_valid are registered and stay stable while m_valid && !m_ready.
- Empty FIFO with a write: m_valid rises the next cycle; there is no same-cycle bypass.
- Full FIFO with a write and no read: the sample is dropped, drop_count increments (saturating), ovf_flag is set.
- Full FIFO with a write and a read in the same cycle: the write is accepted, level is unchanged, nothing is dropped.
- Empty FIFO with m_ready high: no effect.
- level: incremented on write-only, decremented on read-only, unchanged on both or neither.
- Read and write pointers carry one extra wrap bit for the full/empty decision.
- Clipping event: sat_flag is set and sat_count increments (saturating). This is evaluated only for valid stage-2 samples, including samples that are later dropped.
- clr_stats with a concurrent event: the clear applies first and the event is then counted, so the counter reads 1 and the flag stays set.
- Dropped samples leave the order of buffered samples intact.

Decomposition:
- Package fir_pkg: IN_WIDTH/OUT_WIDTH defaults shared with the serial FIR, SAT_MAX/SAT_MIN localparams, and a requant function (round, shift, clip) reused by the bench model.
- One sub-module, fir_sync_fifo (parameters WIDTH, DEPTH): pointers, level, full/empty, FWFT output register.
- fir_out_requant keeps the two-stage arithmetic pipeline and the statistics logic.

Test Plan:
1. Rounding, SHIFT=15, m_ready=1: y_in = 32768000, 16384, -16384, -16385, 49151 -> m_data 1000, 1, 0, -1, 1 in order. First m_valid appears 3 cycles after the first y_valid; sat_count stays 0.
2. Saturation: y_in = 2^36-1 then -2^36 -> m_data 32767 then -32768; sat_flag=1, sat_count=2. Pulse clr_stats -> flag and count return to 0.
3. Back-pressure: m_ready=0, 10 consecutive samples with values 1..10 (times 32768) -> level=8, drop_count=2, ovf_flag=1. Release m_ready -> outputs 1..8 in order, m_data stable while stalled.
4. Full with simultaneous read and write: fill to 8, then one cycle with y_valid and m_ready -> level stays 8, drop_count unchanged, the new sample is delivered last.
5. Reset mid-operation: 5 samples buffered, assert rst asynchronously between edges -> m_valid, level, flags and counters are 0 immediately. After release, a new sample emerges with 3-cycle latency and no stale data.
6. Streaming: 256-sample sine sweep from the serial FIR with m_ready toggling randomly -> every output matches the fir_pkg requant model in order, and drop_count equals the number of writes that occurred with level=8 and no read.
